data_mem_responder: RTL
=======================

# data_mem_responder

Responder end of the CPU data-memory port: accepts the single-cycle load/store requests issued from the execute stage (address, store data, transfer type, read/write enables) and returns load data in the same cycle. Stores commit on the clock edge into an internal word-organised array with byte-lane masking. An optional memory-mapped I/O window adds a 64-bit cycle counter, a sticky error status register and an LED output register. Sits beside the CPU top level as its data memory; instruction fetch is out of scope.

## Interface
- DEPTH_WORDS, 1024: array depth in 32-bit words, power of two; index = MEM_addr[$clog2(DEPTH_WORDS)+1:2], upper bits ignored (aliasing).
- MMIO_BASE, 32'hFFFF_FF00: base of the 16-byte MMIO window; only present with DMEM_MMIO_EN.
- CLK  input  1  sole clock, rising edge.
- Reset  input  1  synchronous, active-high reset, sampled on CLK rising edge.
- MEM_addr  input  32  byte address.
- MEM_WR_out  input  32  store data, right-aligned (rs2 value).
- MEM_type  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal.
- MEM_rd_en  input  1  load request this cycle.
- MEM_wr_en  input  1  store request this cycle.
- MEM_data  output  32  load data, right-aligned and extended per MEM_type; combinational.
- led_out  output  8  LED register (MMIO only; tied 0 otherwise).
- mem_err  output  1  OR of status sticky bits.

## Operation
- Load: MEM_data = selected lane of addressed word, shifted down by MEM_addr[1:0]; B/H sign-extended, BU/HU zero-extended, W passed through. MEM_rd_en low -> MEM_data = 0.
- Store: lane shifted up by MEM_addr[1:0]; byte-enable mask B=1 lane, H=2 lanes, W=4; written at the rising edge when MEM_wr_en=1.
- Misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0) or illegal MEM_type: store suppressed, MEM_data = 0, status bit0 set.
- MEM_rd_en and MEM_wr_en both high: store performed, MEM_data = 0, status bit1 set.
- Array contents not reset; simulation initialises to 0.
- MMIO (DMEM_MMIO_EN): addr in [MMIO_BASE, MMIO_BASE+15] decodes to registers, never to the array.
  - +0 CYCLE_LO (RO): reading returns counter[31:0] and latches counter[63:32] into a shadow register on that edge.
  - +4 CYCLE_HI (RO): returns shadow, giving a consistent 64-bit pair when read after +0.
  - +8 STATUS: bit0 misalign, bit1 rd/wr conflict; write-1-to-clear; new error in same cycle as clear -> bit stays set.
  - +C LED: bits[7:0] R/W, upper bits read 0; byte store to +C writes it.
  - Writes to RO registers ignored; sub-word MMIO accesses follow the same lane rules.

## Timing
- Load latency 0 cycles (combinational addr->data); store visible to a load in the next cycle.
- Load same cycle as store to same word cannot occur legally (conflict rule applies).
- Cycle counter increments every non-reset cycle; wraps 2^64-1 -> 0.
- Reset values: counter 0, shadow 0, STATUS 0, led_out 0, mem_err 0; MEM_data follows inputs (0 when MEM_rd_en low).
- Reset asserted with MEM_wr_en high: array write still suppressed; registers take reset values.

## Configuration
- DMEM_MMIO_EN defined: MMIO window, counter, shadow, STATUS, LED implemented.
- Undefined: all addresses map to the array; led_out = 0; error bits kept internally, mem_err still driven.

## Structure
- Package dmem_pkg: MEM_type encodings (MT_B, MT_H, MT_W, MT_BU, MT_HU), MMIO offsets, STATUS bit indices.
- Sub-module dmem_lane_align: combinational lane shift, byte-enable generation, load extension, misalign detect.

## Test plan
- Store W 32'hDEADBEEF @0x10, next cycle load BU @0x11 -> 32'h000000BE; load B @0x13 -> 32'hFFFFFFDE; load HU @0x12 -> 32'h0000DEAD.
- Store B 32'h000000AA @0x12 over word 0x11223344 -> load W @0x10 returns 32'h11AA3344.
- Store H @0x11 -> array unchanged, mem_err=1 next cycle; STATUS write 32'h1 -> mem_err=0.
- Reset, run 100 cycles, load +0 then +4 -> 64-bit value 100 (±issue cycle), HI consistent; preload counter 32'hFFFFFFFF low wrap -> HI increments.
- MEM_rd_en=MEM_wr_en=1 store W 5 @0x20 -> MEM_data=0, STATUS bit1=1, load @0x20 next cycle = 5.
- Store B 8'h5A @MMIO_BASE+C -> led_out=8'h5A; Reset -> led_out=0; without DMEM_MMIO_EN same address aliases into array.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: transfer types, MMIO offsets, status bits.
package dmem_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned LANES    = 4;
    localparam int unsigned STATUS_W = 2;

    // RISC-V load/store funct3 encodings; any other value is illegal
    typedef enum logic [2:0] {
        MT_B  = 3'b000,
        MT_H  = 3'b001,
        MT_W  = 3'b010,
        MT_BU = 3'b100,
        MT_HU = 3'b101
    } mem_type_e;

    // Byte offsets of the registers inside the 16-byte MMIO window
    localparam logic [3:0] OFF_CYCLE_LO = 4'h0;
    localparam logic [3:0] OFF_CYCLE_HI = 4'h4;
    localparam logic [3:0] OFF_STATUS   = 4'h8;
    localparam logic [3:0] OFF_LED      = 4'hC;

    // Sticky status bit positions
    localparam int unsigned ST_MISALIGN = 0;
    localparam int unsigned ST_CONFLICT = 1;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data port: store shift + byte enables, load shift + extension,
// and misalignment / illegal-type detection. Purely combinational.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]       addr_lo,
    input  logic [2:0]       mem_type,
    input  logic [XLEN-1:0]  wr_data,
    input  logic [XLEN-1:0]  rd_word,
    output logic [XLEN-1:0]  wr_word_c,
    output logic [LANES-1:0] byte_en_c,
    output logic [XLEN-1:0]  rd_data_c,
    output logic             misalign_c
);

    logic [4:0]      sh_amt;
    logic [XLEN-1:0] rd_shift;

    assign sh_amt    = {addr_lo, 3'b000};
    assign rd_shift  = rd_word >> sh_amt;
    assign wr_word_c = wr_data << sh_amt;

    // Decode transfer type into lane mask, load extension and alignment check
    always_comb begin
        byte_en_c  = '0;
        rd_data_c  = '0;
        misalign_c = 1'b0;
        case (mem_type)
            MT_B: begin
                byte_en_c = 4'b0001 << addr_lo;
                rd_data_c = {{24{rd_shift[7]}}, rd_shift[7:0]};
            end
            MT_BU: begin
                byte_en_c = 4'b0001 << addr_lo;
                rd_data_c = {24'd0, rd_shift[7:0]};
            end
            MT_H: begin
                misalign_c = addr_lo[0];
                byte_en_c  = 4'b0011 << addr_lo;
                rd_data_c  = {{16{rd_shift[15]}}, rd_shift[15:0]};
            end
            MT_HU: begin
                misalign_c = addr_lo[0];
                byte_en_c  = 4'b0011 << addr_lo;
                rd_data_c  = {16'd0, rd_shift[15:0]};
            end
            MT_W: begin
                misalign_c = |addr_lo;
                byte_en_c  = 4'b1111;
                rd_data_c  = rd_word;
            end
            default: misalign_c = 1'b1;
        endcase
        if (misalign_c) begin
            byte_en_c = '0;
            rd_data_c = '0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the CPU data port: same-cycle loads, clocked byte-masked stores,
// sticky error status. Defining DMEM_MMIO_EN adds an MMIO window with a 64-bit cycle
// counter (+0 LO / +4 HI shadow), write-1-to-clear STATUS (+8) and an LED register (+C).
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] MEM_addr,
    input  logic [31:0] MEM_WR_out,
    input  logic [2:0]  MEM_type,
    input  logic        MEM_rd_en,
    input  logic        MEM_wr_en,
    output logic [31:0] MEM_data,
    output logic [7:0]  led_out,
    output logic        mem_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [XLEN-1:0]     mem [DEPTH_WORDS];
    logic [IDX_W-1:0]    idx;
    logic [XLEN-1:0]     src_word;
    logic [XLEN-1:0]     wr_word_c;
    logic [LANES-1:0]    byte_en_c;
    logic [XLEN-1:0]     rd_data_c;
    logic                misalign_c;
    logic                store_ok;
    logic                load_ok;
    logic                array_we;
    logic [STATUS_W-1:0] err_new;
    logic [STATUS_W-1:0] status_clr;
    logic [STATUS_W-1:0] status;

    assign idx = MEM_addr[IDX_W+1:2];

    dmem_lane_align u_align (
        .addr_lo    (MEM_addr[1:0]),
        .mem_type   (MEM_type),
        .wr_data    (MEM_WR_out),
        .rd_word    (src_word),
        .wr_word_c  (wr_word_c),
        .byte_en_c  (byte_en_c),
        .rd_data_c  (rd_data_c),
        .misalign_c (misalign_c)
    );

    // A conflicting rd+wr still stores but returns no load data
    assign store_ok = MEM_wr_en & ~misalign_c & ~Reset;
    assign load_ok  = MEM_rd_en & ~MEM_wr_en & ~misalign_c;
    assign MEM_data = load_ok ? rd_data_c : '0;

    assign err_new[ST_MISALIGN] = (MEM_rd_en | MEM_wr_en) & misalign_c;
    assign err_new[ST_CONFLICT] = MEM_rd_en & MEM_wr_en;

`ifdef DMEM_MMIO_EN
    logic        mmio_hit;
    logic [3:0]  mmio_off;
    logic [63:0] cycle_cnt;
    logic [31:0] cycle_hi_shadow;
    logic [XLEN-1:0] mmio_word;
    logic        unused_addr;

    assign mmio_hit    = (MEM_addr[31:4] == MMIO_BASE[31:4]);
    assign mmio_off    = {MEM_addr[3:2], 2'b00};
    assign unused_addr = ^MMIO_BASE[3:0];

    // MMIO register read mux
    always_comb begin
        mmio_word = '0;
        case (mmio_off)
            OFF_CYCLE_LO: mmio_word = cycle_cnt[31:0];
            OFF_CYCLE_HI: mmio_word = cycle_hi_shadow;
            OFF_STATUS:   mmio_word = {30'd0, status};
            OFF_LED:      mmio_word = {24'd0, led_out};
            default:      mmio_word = '0;
        endcase
    end

    assign src_word   = mmio_hit ? mmio_word : mem[idx];
    assign array_we   = store_ok & ~mmio_hit;
    assign status_clr = (store_ok && mmio_hit && mmio_off == OFF_STATUS && byte_en_c[0])
                        ? wr_word_c[STATUS_W-1:0] : '0;

    // Free-running cycle counter and HI shadow captured when LO is read
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cycle_cnt       <= '0;
            cycle_hi_shadow <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (load_ok && mmio_hit && mmio_off == OFF_CYCLE_LO)
                cycle_hi_shadow <= cycle_cnt[63:32];
        end
    end

    // LED register, written through byte lane 0 of +C
    always_ff @(posedge CLK) begin
        if (Reset)
            led_out <= '0;
        else if (store_ok && mmio_hit && mmio_off == OFF_LED && byte_en_c[0])
            led_out <= wr_word_c[7:0];
    end
`else
    logic unused_addr;

    assign src_word    = mem[idx];
    assign array_we    = store_ok;
    assign status_clr  = '0;
    assign led_out     = '0;
    assign unused_addr = ^{MEM_addr[31:IDX_W+2], MMIO_BASE};
`endif

    // Sticky error bits; a new error wins over a simultaneous clear
    always_ff @(posedge CLK) begin
        if (Reset)
            status <= '0;
        else
            status <= (status & ~status_clr) | err_new;
    end

    assign mem_err = |status;

    // Byte-masked array write; contents are never reset
    always_ff @(posedge CLK) begin
        if (array_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (byte_en_c[b])
                    mem[idx][8*b +: 8] <= wr_word_c[8*b +: 8];
            end
        end
    end

endmodule
